// File: rtl/buf_share_pkg.sv
// Shared types and helpers for the buffer-sharing arbiter.
package buf_share_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // A single requester still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/buf_share_arbiter_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping modulo N.
module rr_pick
    import buf_share_pkg::*;
#(
    parameter int N  = 2,
    parameter int PW = idx_w(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [N-1:0]  gnt_onehot_o,
    output logic [PW-1:0] gnt_idx_o,
    output logic          any_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_onehot_o = '0;
        gnt_idx_o    = '0;
        any_o        = 1'b0;
        idx          = '0;
        // Explicit modulo keeps the wrap correct for non-power-of-2 N.
        for (int off = 0; off < N; off++) begin
            idx = PW'((int'(ptr_i) + off) % N);
            if (!any_o && req_i[idx]) begin
                any_o             = 1'b1;
                gnt_idx_o         = idx;
                gnt_onehot_o[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/buf_share_arbiter.sv
// Round-robin arbiter feeding one registered Buf stage from N valid/ready requesters.
// Handshake: a word moves when valid & ready are both high on a rising CLK edge.
module buf_share_arbiter
    import buf_share_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter int               N          = 2,
    parameter logic [WIDTH-1:0] IDLE_VALUE = WIDTH'(1),
    localparam int              GW         = idx_w(N)
) (
    input  logic               CLK,
    input  logic               ASYNCRESETN,
    input  logic [N-1:0]       I_valid,
    output logic [N-1:0]       I_ready,
    input  logic [N*WIDTH-1:0] I_data,
    output logic               O_valid,
    input  logic               O_ready,
    output logic [WIDTH-1:0]   O_data,
    output logic [GW-1:0]      O_grant,
    output state_t             dbg_state_o
);

    state_t           state_q;
    logic [WIDTH-1:0] data_q;
    logic [GW-1:0]    grant_q;
    logic [GW-1:0]    rr_ptr_q;
    logic [GW-1:0]    rr_ptr_d;

    logic [N-1:0]     gnt_onehot;
    logic [GW-1:0]    gnt_idx;
    logic             any;
    logic             can_load;
    logic             xfer;
    logic [WIDTH-1:0] word [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            word[i] = I_data[i*WIDTH +: WIDTH];
        end
    end

    rr_pick #(
        .N  (N),
        .PW (GW)
    ) u_pick (
        .req_i        (I_valid),
        .ptr_i        (rr_ptr_q),
        .gnt_onehot_o (gnt_onehot),
        .gnt_idx_o    (gnt_idx),
        .any_o        (any)
    );

    // A held word that drains this edge frees the slot for a same-edge load.
    assign can_load = (state_q == EMPTY) || O_ready;
    assign xfer     = can_load && any;
    assign I_ready  = can_load ? gnt_onehot : '0;
    assign rr_ptr_d = (gnt_idx == GW'(N - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK or negedge ASYNCRESETN) begin
        if (!ASYNCRESETN) begin
            state_q  <= EMPTY;
            data_q   <= IDLE_VALUE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else if (xfer) begin
            state_q  <= FULL;
            data_q   <= word[gnt_idx];
            grant_q  <= gnt_idx;
            rr_ptr_q <= rr_ptr_d;
        end else if (state_q == FULL && O_ready) begin
            state_q <= EMPTY;
            data_q  <= IDLE_VALUE;
        end
    end

    assign O_valid     = (state_q == FULL);
    assign O_data      = data_q;
    assign O_grant     = grant_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_buf_share_arbiter.sv
// Bench for buf_share_arbiter: directed scenarios plus random traffic against a reference model.
module tb_buf_share_arbiter;
    import buf_share_pkg::*;

    localparam int              W    = 3;
    localparam int              NT   = 2;
    localparam logic [W-1:0]    IDLE = 3'h1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // N=2 instance
    logic [NT-1:0]   i_valid;
    logic [NT-1:0]   i_ready;
    logic [NT*W-1:0] i_data;
    logic            o_valid;
    logic            o_ready;
    logic [W-1:0]    o_data;
    logic [0:0]      o_grant;
    state_t          dbg;

    // N=3 instance
    logic [2:0]      v3;
    logic [2:0]      r3;
    logic [8:0]      d3;
    logic            ov3;
    logic            ordy3;
    logic [W-1:0]    od3;
    logic [1:0]      og3;
    state_t          dbg3;

    buf_share_arbiter #(.WIDTH(W), .N(NT), .IDLE_VALUE(IDLE)) dut (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .I_valid(i_valid), .I_ready(i_ready), .I_data(i_data),
        .O_valid(o_valid), .O_ready(o_ready), .O_data(o_data),
        .O_grant(o_grant), .dbg_state_o(dbg)
    );

    buf_share_arbiter #(.WIDTH(W), .N(3), .IDLE_VALUE(IDLE)) dut3 (
        .CLK(clk), .ASYNCRESETN(rst_n),
        .I_valid(v3), .I_ready(r3), .I_data(d3),
        .O_valid(ov3), .O_ready(ordy3), .O_data(od3),
        .O_grant(og3), .dbg_state_o(dbg3)
    );

    int tests = 0;
    int fails = 0;

    // scoreboard: word currently expected in the Buf stage (0 or 1 entries)
    logic [W-1:0] exp_q[$];
    int m_grant = 0;
    int m_ptr   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int winner(input logic [NT-1:0] v, input int ptr);
        logic [NT-1:0] t;
        for (int k = 0; k < NT; k++) begin
            t = v >> ((ptr + k) % NT);
            if (t[0]) return (ptr + k) % NT;
        end
        return -1;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_grant = 0;
        m_ptr   = 0;
    endtask

    // Check all N=2 outputs against the model, then advance one clock.
    task automatic step();
        logic [NT-1:0]   er;
        logic [NT*W-1:0] t;
        int              w;
        bit              can;
        #1;
        can = (exp_q.size() == 0) || o_ready;
        w   = winner(i_valid, m_ptr);
        er  = '0;
        if (can && w >= 0) er = NT'(1) << w;
        chk("I_ready", 32'(i_ready), 32'(er));
        chk("O_valid", 32'(o_valid), 32'(exp_q.size() != 0));
        chk("O_data", 32'(o_data), 32'((exp_q.size() != 0) ? exp_q[0] : IDLE));
        if (exp_q.size() != 0) chk("O_grant", 32'(o_grant), 32'(m_grant));
        chk("state", 32'(dbg == FULL), 32'(exp_q.size() != 0));
        @(posedge clk);
        if (exp_q.size() != 0 && o_ready) void'(exp_q.pop_front());
        if (can && w >= 0) begin
            t = i_data >> (w * W);
            exp_q.push_back(t[W-1:0]);
            m_grant = w;
            m_ptr   = (w + 1) % NT;
        end
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        i_valid = '0;
        i_data  = '0;
        o_ready = 1'b0;
        v3      = '0;
        d3      = '0;
        ordy3   = 1'b1;
        model_reset();
        #12;
        chk("rst_O_valid", 32'(o_valid), 32'(0));
        chk("rst_O_data", 32'(o_data), 32'(IDLE));
        chk("rst_O_grant", 32'(o_grant), 32'(0));
        chk("rst_I_ready", 32'(i_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // idle cycles
        repeat (5) step();

        // single transfer from requester 0
        i_valid = 2'b01;
        i_data  = {3'h0, 3'h5};
        o_ready = 1'b1;
        #1 chk("t2_I_ready", 32'(i_ready), 32'(2'b01));
        step();
        i_valid = 2'b00;
        chk("t2_O_valid", 32'(o_valid), 32'(1));
        chk("t2_O_data", 32'(o_data), 32'(3'h5));
        chk("t2_O_grant", 32'(o_grant), 32'(0));
        step();

        // both requesting: back-to-back alternation
        i_valid = 2'b11;
        i_data  = {3'h6, 3'h2};
        repeat (6) step();
        chk("t3_O_valid", 32'(o_valid), 32'(1));
        i_valid = 2'b00;
        step();

        // stall with held word
        i_valid = 2'b01;
        i_data  = {3'h7, 3'h3};
        o_ready = 1'b1;
        step();
        i_valid = 2'b10;
        o_ready = 1'b0;
        repeat (4) begin
            step();
            chk("t4_hold_data", 32'(o_data), 32'(3'h3));
            chk("t4_hold_ready", 32'(i_ready), 32'(0));
        end
        o_ready = 1'b1;
        #1 chk("t4_rel_ready", 32'(i_ready), 32'(2'b10));
        step();
        chk("t4_next_data", 32'(o_data), 32'(3'h7));
        chk("t4_next_grant", 32'(o_grant), 32'(1));
        i_valid = 2'b00;
        step();
        step();

        // async reset while FULL
        i_valid = 2'b01;
        i_data  = {3'h0, 3'h3};
        o_ready = 1'b0;
        step();
        chk("t5_full", 32'(o_valid), 32'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(o_valid), 32'(0));
        chk("t5_rst_data", 32'(o_data), 32'(IDLE));
        chk("t5_rst_state", 32'(dbg == EMPTY), 32'(1));
        model_reset();
        i_valid = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 2'b11;
        i_data  = {3'h4, 3'h6};
        o_ready = 1'b1;
        #1 chk("t5_prio_ready", 32'(i_ready), 32'(2'b01));
        step();
        chk("t5_prio_grant", 32'(o_grant), 32'(0));
        i_valid = 2'b00;
        step();
        step();

        // N=3 wrap: requester 1 idle
        d3 = {3'h7, 3'h4, 3'h2};
        v3 = 3'b100;
        #1 chk("t6_r3_a", 32'(r3), 32'(3'b100));
        step();
        chk("t6_g_a", 32'(og3), 32'(2));
        chk("t6_d_a", 32'(od3), 32'(3'h7));
        v3 = 3'b101;
        #1 chk("t6_r3_b", 32'(r3), 32'(3'b001));
        step();
        chk("t6_g_b", 32'(og3), 32'(0));
        chk("t6_d_b", 32'(od3), 32'(3'h2));
        #1 chk("t6_r3_c", 32'(r3), 32'(3'b100));
        step();
        chk("t6_g_c", 32'(og3), 32'(2));
        chk("t6_r3_d", 32'(r3), 32'(3'b001));
        step();
        chk("t6_g_d", 32'(og3), 32'(0));
        v3 = 3'b000;
        step();
        chk("t6_idle_valid", 32'(ov3), 32'(0));
        chk("t6_idle_data", 32'(od3), 32'(IDLE));

        // random traffic
        for (int n = 0; n < 400; n++) begin
            i_valid = NT'($urandom_range(0, 3));
            i_data  = (NT*W)'($urandom);
            o_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
